hazard_ctrl_unit: RTL

Parametrised successor to the pipeline hazard detector for the 5-stage RV32I core. It decides, every cycle, the stage write-enables and flushes for IF/ID/EX/MEM/WB. It handles load-use hazards with configurable bubble count, EX-stage control redirects, and multi-cycle data-memory waits with a timeout. A small FSM and counters hold stall state across cycles. Stall and flush performance counters are exported to the debug bus.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_ctrl_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_e;

   localparam int unsigned LU_BUBBLES_DEF  = 1;
   localparam int unsigned MEM_TIMEOUT_DEF = 15;

   // Wait counter must hold MEM_TIMEOUT, and is never narrower than 4 bits.
   function automatic int unsigned wait_cnt_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout + 1);
      return (w < 4) ? 4 : w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stage write-enable / flush controller for the 5-stage core: load-use bubbles,
// EX redirects and data-memory waits with a sticky timeout flag.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LU_BUBBLES  = LU_BUBBLES_DEF,
   parameter int unsigned MEM_WAIT_EN = 1,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_rs1_used,
   input  logic              i_id_rs2_used,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_ex_mem_read,
   input  logic              i_ex_redirect,
   input  logic              i_mem_req,
   input  logic              i_mem_ready,
   output logic              o_pc_we,
   output logic              o_ifid_we,
   output logic              o_idex_we,
   output logic              o_exmem_we,
   output logic              o_ifid_flush,
   output logic              o_idex_flush,
   output logic              o_memwb_flush,
   output logic              o_mem_err,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);

   localparam int unsigned     WAIT_W     = wait_cnt_width(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [1:0]      LU_LOAD    = 2'(LU_BUBBLES - 1);

   hz_state_e         r_state, w_state_nxt;
   logic [1:0]        r_lu_cnt, w_lu_cnt_nxt;
   logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic              r_mem_err, w_mem_err_nxt;

   logic w_rs1_hit, w_rs2_hit, w_load_use, w_mem_stall, w_redirect, w_lu_stall;

   always_comb begin
      w_rs1_hit   = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
      w_rs2_hit   = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
      w_load_use  = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
      w_mem_stall = (MEM_WAIT_EN != 0) && i_mem_req && !i_mem_ready && !r_mem_err;
      w_redirect  = i_ex_redirect && !w_mem_stall;
      // In LU_STALL the bubble count alone decides; load_use is not re-evaluated.
      w_lu_stall  = !w_mem_stall && !i_ex_redirect &&
                    ((r_state == LU_STALL) || w_load_use);
   end

   always_comb begin
      o_pc_we       = 1'b1;
      o_ifid_we     = 1'b1;
      o_idex_we     = 1'b1;
      o_exmem_we    = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idex_flush  = 1'b0;
      o_memwb_flush = 1'b0;
      if (rst) begin
         o_pc_we       = 1'b0;
         o_ifid_we     = 1'b0;
         o_idex_we     = 1'b0;
         o_exmem_we    = 1'b0;
         o_ifid_flush  = 1'b1;
         o_idex_flush  = 1'b1;
         o_memwb_flush = 1'b1;
      end else if (w_mem_stall) begin
         o_pc_we       = 1'b0;
         o_ifid_we     = 1'b0;
         o_idex_we     = 1'b0;
         o_exmem_we    = 1'b0;
         o_memwb_flush = 1'b1;
      end else if (w_redirect) begin
         o_ifid_flush = 1'b1;
         o_idex_flush = 1'b1;
      end else if (w_lu_stall) begin
         o_pc_we      = 1'b0;
         o_ifid_we    = 1'b0;
         o_idex_flush = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_lu_cnt_nxt   = r_lu_cnt;
      w_wait_cnt_nxt = '0;
      w_mem_err_nxt  = r_mem_err;
      if (w_mem_stall) begin
         if (r_wait_cnt != '1) begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
         end else begin
            w_wait_cnt_nxt = r_wait_cnt;
         end
         if (r_wait_cnt >= TIMEOUT_M1) begin
            w_mem_err_nxt = 1'b1;
         end
      end else if (w_redirect) begin
         w_state_nxt  = RUN;
         w_lu_cnt_nxt = '0;
      end else if (r_state == LU_STALL) begin
         if (r_lu_cnt <= 2'd1) begin
            w_state_nxt  = RUN;
            w_lu_cnt_nxt = '0;
         end else begin
            w_lu_cnt_nxt = r_lu_cnt - 2'd1;
         end
      end else if (w_load_use && (LU_BUBBLES > 1)) begin
         w_state_nxt  = LU_STALL;
         w_lu_cnt_nxt = LU_LOAD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_lu_cnt   <= '0;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lu_cnt   <= w_lu_cnt_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_mem_err  <= w_mem_err_nxt;
      end
   end

   assign o_mem_err = r_mem_err;

   logic w_stall_inc;
   assign w_stall_inc = !o_pc_we && !rst;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_stall_inc),
      .i_clr (1'b0),
      .o_cnt (o_stall_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_redirect),
      .i_clr (1'b0),
      .o_cnt (o_flush_cnt)
   );

endmodule
